// File: rtl/ld_ec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ld_ec_pkg
//  Desc     : Shared types and constants for the Lopez-Dahab point adder:
//             FSM state encoding, step count, default field parameters and
//             the schedule-slot indices of the shared multiplier.
//  Revision : 1.0  initial release
// ============================================================================
package ld_ec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    localparam int LD_NUM_STEPS = 20;
    localparam int LD_STEP_W    = 5;

    // Default field: GF(2^4) with x^4 + x + 1, curve coefficient a = x^2
    localparam int         LD_DEF_M      = 4;
    localparam logic [4:0] LD_DEF_POLY   = 5'b10011;
    localparam logic [3:0] LD_DEF_A_COEF = 4'b0100;

    // Schedule slots; each step also owns the bank entry of the same index
    localparam logic [LD_STEP_W-1:0] ST_Z0SQ = 5'd0;   // Z0^2
    localparam logic [LD_STEP_W-1:0] ST_Z1SQ = 5'd1;   // Z1^2
    localparam logic [LD_STEP_W-1:0] ST_A0   = 5'd2;   // Y1*Z0^2
    localparam logic [LD_STEP_W-1:0] ST_C    = 5'd3;   // A0 + Y0*Z1^2
    localparam logic [LD_STEP_W-1:0] ST_B0   = 5'd4;   // X1*Z0
    localparam logic [LD_STEP_W-1:0] ST_D    = 5'd5;   // B0 + X0*Z1
    localparam logic [LD_STEP_W-1:0] ST_E    = 5'd6;   // Z0*Z1
    localparam logic [LD_STEP_W-1:0] ST_F    = 5'd7;   // D*E
    localparam logic [LD_STEP_W-1:0] ST_Z2   = 5'd8;   // F^2
    localparam logic [LD_STEP_W-1:0] ST_E2   = 5'd9;   // E^2
    localparam logic [LD_STEP_W-1:0] ST_T    = 5'd10;  // F + a*E^2
    localparam logic [LD_STEP_W-1:0] ST_D2   = 5'd11;  // D^2
    localparam logic [LD_STEP_W-1:0] ST_G    = 5'd12;  // D^2*T
    localparam logic [LD_STEP_W-1:0] ST_H    = 5'd13;  // C*F
    localparam logic [LD_STEP_W-1:0] ST_X2   = 5'd14;  // C^2 + H + G
    localparam logic [LD_STEP_W-1:0] ST_U    = 5'd15;  // D^2*B0
    localparam logic [LD_STEP_W-1:0] ST_I    = 5'd16;  // U*E + X2
    localparam logic [LD_STEP_W-1:0] ST_J    = 5'd17;  // D^2*A0 + X2
    localparam logic [LD_STEP_W-1:0] ST_V    = 5'd18;  // H*I
    localparam logic [LD_STEP_W-1:0] ST_Y2   = 5'd19;  // V + Z2*J

endpackage
`default_nettype wire

// File: rtl/gf2m_mult.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_mult
//  Desc     : Combinational GF(2^M) multiplier, polynomial basis, reduced
//             modulo POLY. Horner-style: walk multiplier bits MSB first,
//             doubling (times x, reduce) then conditionally adding i_a.
//  Revision : 1.0  initial release
// ============================================================================
module gf2m_mult
    import ld_ec_pkg::*;
#(
    parameter int           M    = LD_DEF_M,
    parameter logic [M:0]   POLY = LD_DEF_POLY
) (
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_p
);

    logic [M-1:0] w_acc;

    // Shift-and-add product with on-the-fly reduction
    always_comb begin
        w_acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            w_acc = {w_acc[M-2:0], 1'b0} ^ (w_acc[M-1] ? POLY[M-1:0] : '0);
            if (i_b[i]) begin
                w_acc = w_acc ^ i_a;
            end
        end
        o_p = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/ld_point_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ld_point_add_seq
//  Desc     : Sequential Lopez-Dahab projective point adder over GF(2^M).
//             One shared multiplier runs a fixed 20-step schedule; field
//             additions are folded into the step that consumes them.
//             Optional macro LD_PADD_INF_EN adds a point-at-infinity bypass
//             (Z0==0 or Z1==0 at capture skips the schedule).
//  Revision : 1.0  initial release
// ============================================================================
module ld_point_add_seq
    import ld_ec_pkg::*;
#(
    parameter int           M      = LD_DEF_M,
    parameter logic [M:0]   POLY   = LD_DEF_POLY,
    parameter logic [M-1:0] A_COEF = LD_DEF_A_COEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] X0,
    input  logic [M-1:0] Y0,
    input  logic [M-1:0] Z0,
    input  logic [M-1:0] X1,
    input  logic [M-1:0] Y1,
    input  logic [M-1:0] Z1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] X2,
    output logic [M-1:0] Y2,
    output logic [M-1:0] Z2
);

    ld_state_t            r_state;
    ld_state_t            w_state_nxt;
    logic [LD_STEP_W-1:0] r_step;
    logic [LD_STEP_W-1:0] w_step_nxt;

    logic [M-1:0] r_x0, r_y0, r_z0, r_x1, r_y1, r_z1;
    logic [M-1:0] r_bank [0:LD_NUM_STEPS-1];
    logic [M-1:0] r_x2, r_y2, r_z2;

    logic [M-1:0] w_opa, w_opb, w_add, w_prod, w_res;
    logic         w_accept;
    logic         w_inf;

    // in_ready is held low while reset is asserted
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_res     = w_prod ^ w_add;

    assign X2 = r_x2;
    assign Y2 = r_y2;
    assign Z2 = r_z2;

`ifdef LD_PADD_INF_EN
    logic [M-1:0] w_byp_x, w_byp_y, w_byp_z;

    assign w_inf = (Z0 == '0) || (Z1 == '0);

    // Bypass result: the finite operand, or infinity when both are infinite
    always_comb begin
        w_byp_x = '0;
        w_byp_y = '0;
        w_byp_z = '0;
        if ((Z0 == '0) && (Z1 != '0)) begin
            w_byp_x = X1;
            w_byp_y = Y1;
            w_byp_z = Z1;
        end else if ((Z0 != '0) && (Z1 == '0)) begin
            w_byp_x = X0;
            w_byp_y = Y0;
            w_byp_z = Z0;
        end
    end
`else
    assign w_inf = 1'b0;
`endif

    gf2m_mult #(
        .M    (M),
        .POLY (POLY)
    ) u_mult (
        .i_a (w_opa),
        .i_b (w_opb),
        .o_p (w_prod)
    );

    // Multiplier operand selection and folded addend for the current step
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        w_add = '0;
        case (r_step)
            ST_Z0SQ: begin w_opa = r_z0;            w_opb = r_z0;            end
            ST_Z1SQ: begin w_opa = r_z1;            w_opb = r_z1;            end
            ST_A0:   begin w_opa = r_y1;            w_opb = r_bank[ST_Z0SQ]; end
            ST_C:    begin w_opa = r_y0;            w_opb = r_bank[ST_Z1SQ];
                           w_add = r_bank[ST_A0];                            end
            ST_B0:   begin w_opa = r_x1;            w_opb = r_z0;            end
            ST_D:    begin w_opa = r_x0;            w_opb = r_z1;
                           w_add = r_bank[ST_B0];                            end
            ST_E:    begin w_opa = r_z0;            w_opb = r_z1;            end
            ST_F:    begin w_opa = r_bank[ST_D];    w_opb = r_bank[ST_E];    end
            ST_Z2:   begin w_opa = r_bank[ST_F];    w_opb = r_bank[ST_F];    end
            ST_E2:   begin w_opa = r_bank[ST_E];    w_opb = r_bank[ST_E];    end
            ST_T:    begin w_opa = A_COEF;          w_opb = r_bank[ST_E2];
                           w_add = r_bank[ST_F];                             end
            ST_D2:   begin w_opa = r_bank[ST_D];    w_opb = r_bank[ST_D];    end
            ST_G:    begin w_opa = r_bank[ST_D2];   w_opb = r_bank[ST_T];    end
            ST_H:    begin w_opa = r_bank[ST_C];    w_opb = r_bank[ST_F];    end
            ST_X2:   begin w_opa = r_bank[ST_C];    w_opb = r_bank[ST_C];
                           w_add = r_bank[ST_H] ^ r_bank[ST_G];              end
            ST_U:    begin w_opa = r_bank[ST_D2];   w_opb = r_bank[ST_B0];   end
            ST_I:    begin w_opa = r_bank[ST_U];    w_opb = r_bank[ST_E];
                           w_add = r_bank[ST_X2];                            end
            ST_J:    begin w_opa = r_bank[ST_D2];   w_opb = r_bank[ST_A0];
                           w_add = r_bank[ST_X2];                            end
            ST_V:    begin w_opa = r_bank[ST_H];    w_opb = r_bank[ST_I];    end
            ST_Y2:   begin w_opa = r_bank[ST_Z2];   w_opb = r_bank[ST_J];
                           w_add = r_bank[ST_V];                             end
            default: ;
        endcase
    end

    // State and step-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC (or DONE on bypass) -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_step_nxt  = '0;
                    w_state_nxt = w_inf ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_step == ST_Y2) begin
                    w_step_nxt  = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_step_nxt  = r_step + LD_STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    // Operand capture, intermediate bank writes and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_z0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
            r_z1 <= '0;
            r_x2 <= '0;
            r_y2 <= '0;
            r_z2 <= '0;
            for (int k = 0; k < LD_NUM_STEPS; k++) begin
                r_bank[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_x0 <= X0;
                r_y0 <= Y0;
                r_z0 <= Z0;
                r_x1 <= X1;
                r_y1 <= Y1;
                r_z1 <= Z1;
`ifdef LD_PADD_INF_EN
                if (w_inf) begin
                    r_x2 <= w_byp_x;
                    r_y2 <= w_byp_y;
                    r_z2 <= w_byp_z;
                end
`endif
            end
            if (r_state == CALC) begin
                r_bank[r_step] <= w_res;
                // Results only update as the schedule completes, so they
                // stay stable throughout DONE
                if (r_step == ST_Y2) begin
                    r_x2 <= r_bank[ST_X2];
                    r_y2 <= w_res;
                    r_z2 <= r_bank[ST_Z2];
                end
            end
        end
    end

endmodule
`default_nettype wire
